// File: rtl/stack_pkg.sv
// Shared types and helpers for the stack sequencer: op codes, FSM states,
// words-per-PC derivation and per-op beat counts.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_INT  = 3'd4,
    OP_RTI  = 3'd5,
    OP_NOP6 = 3'd6,
    OP_NOP7 = 3'd7
  } stack_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } stack_state_e;

  function automatic int calc_nw(input int pc_w, input int data_w);
    return (pc_w + data_w - 1) / data_w;
  endfunction

  function automatic int words_for_op(input stack_op_e op, input int nw);
    int n;
    case (op)
      OP_PUSH, OP_POP: n = 1;
      OP_CALL, OP_RET: n = nw;
      OP_INT, OP_RTI:  n = nw + 1;
      default:         n = 0;
    endcase
    return n;
  endfunction

  function automatic logic op_is_valid(input stack_op_e op);
    return (op <= OP_RTI) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic op_is_push(input stack_op_e op);
    logic r;
    case (op)
      OP_PUSH, OP_CALL, OP_INT: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_pop(input stack_op_e op);
    logic r;
    case (op)
      OP_POP, OP_RET, OP_RTI: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stack_engine_if.sv
// Data-memory beat port shared by the stack engine (master) and the memory (slave).
interface stack_engine_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/stack_word_mux.sv
// Beat-level word steering: picks the word written on each push beat and
// scatters each popped word back into the PC / flag accumulators.
module stack_word_mux
  import stack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int FLAG_W = 3,
  parameter int NW     = 2,
  parameter int BEAT_W = 2
) (
  input  stack_op_e              wr_op,
  input  logic [BEAT_W-1:0]      wr_idx,
  input  logic [PC_W-1:0]        wr_pc,
  input  logic [FLAG_W-1:0]      wr_flags,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [DATA_W-1:0]      wr_word,
  input  stack_op_e              rd_op,
  input  logic [BEAT_W-1:0]      rd_idx,
  input  logic [DATA_W-1:0]      rd_data,
  input  logic [NW*DATA_W-1:0]   pc_acc_q,
  input  logic [FLAG_W-1:0]      flags_acc_q,
  output logic [NW*DATA_W-1:0]   pc_acc_d,
  output logic [FLAG_W-1:0]      flags_acc_d
);

  logic [NW*DATA_W-1:0] pc_ext_s;
  logic [DATA_W-1:0]    pc_word_s;
  logic [DATA_W-1:0]    flag_word_s;
  int                   pc_tgt_s;

  // Zero-pad the PC to whole words and slice out the word for this beat
  always_comb begin
    pc_ext_s = '0;
    pc_ext_s[PC_W-1:0] = wr_pc;
    pc_word_s = '0;
    for (int k = 0; k < NW; k++) begin
      if (int'(wr_idx) == k) begin
        pc_word_s = pc_ext_s[k*DATA_W +: DATA_W];
      end else begin
        pc_word_s = pc_word_s;
      end
    end
    flag_word_s = '0;
    flag_word_s[FLAG_W-1:0] = wr_flags;
  end

  // Push order: PC words LSW first, then (INT only) the flag word
  always_comb begin
    wr_word = '0;
    case (wr_op)
      OP_PUSH: wr_word = wr_data;
      OP_CALL: wr_word = pc_word_s;
      OP_INT: begin
        if (int'(wr_idx) < NW) begin
          wr_word = pc_word_s;
        end else begin
          wr_word = flag_word_s;
        end
      end
      default: wr_word = '0;
    endcase
  end

  // Pop order mirrors the push: RTI takes flags first, then PC MSW down to LSW
  always_comb begin
    pc_acc_d    = pc_acc_q;
    flags_acc_d = flags_acc_q;
    pc_tgt_s    = -1;
    case (rd_op)
      OP_RET: pc_tgt_s = NW - 1 - int'(rd_idx);
      OP_RTI: begin
        if (rd_idx == '0) begin
          flags_acc_d = rd_data[FLAG_W-1:0];
        end else begin
          pc_tgt_s = NW - int'(rd_idx);
        end
      end
      default: pc_tgt_s = -1;
    endcase
    for (int k = 0; k < NW; k++) begin
      if (k == pc_tgt_s) begin
        pc_acc_d[k*DATA_W +: DATA_W] = rd_data;
      end else begin
        pc_acc_d[k*DATA_W +: DATA_W] = pc_acc_d[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/stack_engine.sv
// Multi-cycle stack sequencer: PUSH/POP/CALL/RET/INT/RTI over a shared memory
// beat port. Define STACK_BOUND_CHECK_EN to reject ops that over/underflow.
module stack_engine
  import stack_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          PC_W        = 32,
  parameter int          FLAG_W      = 3,
  parameter int          ADDR_W      = 12,
  parameter int unsigned SP_RESET    = (2**ADDR_W) - 1,
  parameter int          STACK_LIMIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_code,
  input  logic [DATA_W-1:0]  op_data,
  input  logic [PC_W-1:0]    op_pc,
  input  logic [FLAG_W-1:0]  op_flags,
  input  logic               flush,
  stack_engine_if.master     mem,
  output logic               done,
  output logic [DATA_W-1:0]  pop_data,
  output logic [PC_W-1:0]    pc_out,
  output logic [FLAG_W-1:0]  flags_out,
  output logic               err,
  output logic [ADDR_W-1:0]  sp
);

  localparam int NW     = calc_nw(PC_W, DATA_W);
  localparam int BEAT_W = $clog2(NW + 2);

  if (FLAG_W > DATA_W || STACK_LIMIT < 0 || STACK_LIMIT > int'(SP_RESET)) begin : g_bad_params
    $error("stack_engine: inconsistent FLAG_W / STACK_LIMIT / SP_RESET");
  end

  stack_state_e         state_q, state_d;
  stack_op_e            op_q, op_d, op_code_s;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [FLAG_W-1:0]    flags_q, flags_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [BEAT_W-1:0]    beats_q, beats_d, beat_q, beat_d;
  logic [ADDR_W-1:0]    sp_work_q, sp_work_d, sp_q, sp_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [NW*DATA_W-1:0] pc_acc_q, pc_acc_d, mux_pc_acc_s;
  logic [FLAG_W-1:0]    flags_acc_q, flags_acc_d, mux_flags_acc_s;
  logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d, wr_word_s;
  logic                 done_q, done_d, err_q, err_d, op_ready_q, op_ready_d;
  logic [DATA_W-1:0]    pop_data_q, pop_data_d;
  logic [PC_W-1:0]      pc_out_q, pc_out_d;
  logic [FLAG_W-1:0]    flags_out_q, flags_out_d;
  logic                 bound_fail_s;
  int                   n_words_s;

  assign op_code_s = stack_op_e'(op_code);
  assign n_words_s = words_for_op(op_code_s, NW);

`ifdef STACK_BOUND_CHECK_EN
  // Whole-op range check against the committed SP, done once at acceptance
  always_comb begin
    bound_fail_s = 1'b0;
    if (op_is_push(op_code_s)) begin
      bound_fail_s = ((int'(sp_q) - n_words_s + 1) < STACK_LIMIT);
    end else if (op_is_pop(op_code_s)) begin
      bound_fail_s = ((int'(sp_q) + n_words_s) > int'(SP_RESET));
    end else begin
      bound_fail_s = 1'b0;
    end
  end
`else
  assign bound_fail_s = 1'b0;
`endif

  stack_word_mux #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .FLAG_W (FLAG_W),
    .NW     (NW),
    .BEAT_W (BEAT_W)
  ) u_word_mux (
    .wr_op       (op_d),
    .wr_idx      (beat_d),
    .wr_pc       (pc_d),
    .wr_flags    (flags_d),
    .wr_data     (data_d),
    .wr_word     (wr_word_s),
    .rd_op       (op_q),
    .rd_idx      (beat_q),
    .rd_data     (mem.mem_rdata),
    .pc_acc_q    (pc_acc_q),
    .flags_acc_q (flags_acc_q),
    .pc_acc_d    (mux_pc_acc_s),
    .flags_acc_d (mux_flags_acc_s)
  );

  // Sequencer: acceptance, beat progress, flush abort and completion commit
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    pc_d         = pc_q;
    flags_d      = flags_q;
    data_d       = data_q;
    beats_d      = beats_q;
    beat_d       = beat_q;
    sp_work_d    = sp_work_q;
    sp_d         = sp_q;
    flush_pend_d = flush_pend_q;
    pc_acc_d     = pc_acc_q;
    flags_acc_d  = flags_acc_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    pop_data_d   = pop_data_q;
    pc_out_d     = pc_out_q;
    flags_out_d  = flags_out_q;
    case (state_q)
      ST_IDLE: begin
        flush_pend_d = 1'b0;
        if (op_valid && !flush && op_is_valid(op_code_s)) begin
          if (bound_fail_s) begin
            err_d = 1'b1;
          end else begin
            op_d      = op_code_s;
            pc_d      = op_pc;
            flags_d   = op_flags;
            data_d    = op_data;
            beats_d   = BEAT_W'(n_words_s);
            beat_d    = '0;
            sp_work_d = sp_q;
            state_d   = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        flush_pend_d = flush_pend_q | flush;
        if (mem.mem_gnt) begin
          if (mem_we_q) begin
            sp_work_d = sp_work_q - ADDR_W'(1);
            beat_d    = beat_q + BEAT_W'(1);
            if (flush_pend_q || flush) begin
              state_d = ST_IDLE;
            end else if (beat_d == beats_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              sp_d    = sp_work_d;
            end else begin
              state_d = ST_ISSUE;
            end
          end else begin
            // Pop beats pre-increment; the read address is the new SP_work
            sp_work_d = sp_work_q + ADDR_W'(1);
            state_d   = ST_WAIT_RD;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_RD: begin
        flush_pend_d = flush_pend_q | flush;
        if (mem.mem_rvalid) begin
          pc_acc_d    = mux_pc_acc_s;
          flags_acc_d = mux_flags_acc_s;
          beat_d      = beat_q + BEAT_W'(1);
          if (flush_pend_q || flush) begin
            state_d = ST_IDLE;
          end else if (beat_d == beats_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            sp_d    = sp_work_q;
            if (op_q == OP_POP) begin
              pop_data_d = mem.mem_rdata;
            end else begin
              pc_out_d = pc_acc_d[PC_W-1:0];
            end
            if (op_q == OP_RTI) begin
              flags_out_d = flags_acc_d;
            end else begin
              flags_out_d = flags_out_q;
            end
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    op_ready_d = (state_d == ST_IDLE);
  end

  // Next-beat bus drive, registered so addr/we/wdata stay put until granted
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == ST_ISSUE) begin
      mem_req_d = 1'b1;
      mem_we_d  = op_is_push(op_d);
      if (mem_we_d) begin
        mem_addr_d  = sp_work_d;
        mem_wdata_d = wr_word_s;
      end else begin
        mem_addr_d  = sp_work_d + ADDR_W'(1);
        mem_wdata_d = '0;
      end
    end else begin
      mem_req_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_PUSH;
      pc_q         <= '0;
      flags_q      <= '0;
      data_q       <= '0;
      beats_q      <= '0;
      beat_q       <= '0;
      sp_work_q    <= ADDR_W'(SP_RESET);
      sp_q         <= ADDR_W'(SP_RESET);
      flush_pend_q <= 1'b0;
      pc_acc_q     <= '0;
      flags_acc_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      op_ready_q   <= 1'b1;
      pop_data_q   <= '0;
      pc_out_q     <= '0;
      flags_out_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      pc_q         <= pc_d;
      flags_q      <= flags_d;
      data_q       <= data_d;
      beats_q      <= beats_d;
      beat_q       <= beat_d;
      sp_work_q    <= sp_work_d;
      sp_q         <= sp_d;
      flush_pend_q <= flush_pend_d;
      pc_acc_q     <= pc_acc_d;
      flags_acc_q  <= flags_acc_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      op_ready_q   <= op_ready_d;
      pop_data_q   <= pop_data_d;
      pc_out_q     <= pc_out_d;
      flags_out_q  <= flags_out_d;
    end
  end

  assign op_ready      = op_ready_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign done          = done_q;
  assign err           = err_q;
  assign pop_data      = pop_data_q;
  assign pc_out        = pc_out_q;
  assign flags_out     = flags_out_q;
  assign sp            = sp_q;

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine with a behavioural memory and hand-computed
// expectations; follows STACK_BOUND_CHECK_EN for the underflow case.
module tb_stack_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = 3'd0;
  logic [15:0] op_data = 16'h0000;
  logic [31:0] op_pc = 32'h0;
  logic [2:0]  op_flags = 3'b000;
  logic        flush = 1'b0;
  logic        done, err;
  logic [15:0] pop_data;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;
  logic [11:0] sp;
  logic        gnt_en = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem_arr [0:4095];
  logic [11:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  logic [11:0] rd_addr_log[$];

  stack_engine_if #(.ADDR_W(12), .DATA_W(16)) mif ();

  stack_engine dut (
    .clk       (clk),
    .rst       (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_data   (op_data),
    .op_pc     (op_pc),
    .op_flags  (op_flags),
    .flush     (flush),
    .mem       (mif),
    .done      (done),
    .pop_data  (pop_data),
    .pc_out    (pc_out),
    .flags_out (flags_out),
    .err       (err),
    .sp        (sp)
  );

  always #5 clk = ~clk;

  assign mif.mem_gnt = gnt_en;

  // Behavioural memory: write on grant, read data one cycle after read grant
  always @(posedge clk) begin
    mif.mem_rvalid <= 1'b0;
    if (mif.mem_req && mif.mem_gnt) begin
      if (mif.mem_we) begin
        mem_arr[mif.mem_addr] <= mif.mem_wdata;
        wr_addr_log.push_back(mif.mem_addr);
        wr_data_log.push_back(mif.mem_wdata);
      end else begin
        mif.mem_rvalid <= 1'b1;
        mif.mem_rdata  <= mem_arr[mif.mem_addr];
        rd_addr_log.push_back(mif.mem_addr);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic run_op(input logic [2:0] code, input logic [15:0] d, input logic [31:0] pc,
                        input logic [2:0] fl, output int lat);
    @(negedge clk);
    op_valid = 1'b1; op_code = code; op_data = d; op_pc = pc; op_flags = fl;
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, wb, rb;
    bit saw_done;

    #12;
    check_eq("rst_op_ready", op_ready, 1);
    check_eq("rst_sp", sp, 12'hFFF);
    check_eq("rst_mem_req", mif.mem_req, 0);
    check_eq("rst_done_err", {done, err}, 0);
    check_eq("rst_results", {pop_data, pc_out, flags_out}, 0);
    @(negedge clk); rst_n = 1'b1;

    // CALL 0x0001_2345
    wb = wr_addr_log.size();
    run_op(3'd2, 16'h0, 32'h0001_2345, 3'b000, lat);
    check_eq("call_lat", lat, 3);
    check_eq("call_sp", sp, 12'hFFD);
    check_eq("call_w0", {wr_addr_log[wb], wr_data_log[wb]}, {12'hFFF, 16'h2345});
    check_eq("call_w1", {wr_addr_log[wb+1], wr_data_log[wb+1]}, {12'hFFE, 16'h0001});

    // RET
    rb = rd_addr_log.size();
    run_op(3'd3, 16'h0, 32'h0, 3'b000, lat);
    check_eq("ret_lat", lat, 5);
    check_eq("ret_pc", pc_out, 32'h0001_2345);
    check_eq("ret_sp", sp, 12'hFFF);
    check_eq("ret_rd", {rd_addr_log[rb], rd_addr_log[rb+1]}, {12'hFFE, 12'hFFF});

    // INT then RTI
    wb = wr_addr_log.size();
    run_op(3'd4, 16'h0, 32'h0000_0040, 3'b101, lat);
    check_eq("int_lat", lat, 4);
    check_eq("int_sp", sp, 12'hFFC);
    check_eq("int_wpc", {wr_data_log[wb], wr_data_log[wb+1]}, {16'h0040, 16'h0000});
    check_eq("int_wflags", {wr_addr_log[wb+2], wr_data_log[wb+2]}, {12'hFFD, 16'h0005});
    rb = rd_addr_log.size();
    run_op(3'd5, 16'h0, 32'h0, 3'b000, lat);
    check_eq("rti_lat", lat, 7);
    check_eq("rti_flags", flags_out, 3'b101);
    check_eq("rti_pc", pc_out, 32'h40);
    check_eq("rti_sp", sp, 12'hFFF);
    check_eq("rti_rd0", rd_addr_log[rb], 12'hFFD);

    // PUSH 0xBEEF with grant withheld for three cycles
    gnt_en = 1'b0;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd0; op_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op_valid = 1'b0;
      check_eq("stall_bus", {mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata},
               {1'b1, 1'b1, 12'hFFF, 16'hBEEF});
    end
    @(negedge clk);
    check_eq("stall_hold", {mif.mem_req, mif.mem_addr, done}, {1'b1, 12'hFFF, 1'b0});
    gnt_en = 1'b1;
    @(negedge clk);
    check_eq("stall_done", done, 1);
    check_eq("stall_sp", sp, 12'hFFE);

    run_op(3'd1, 16'h0, 32'h0, 3'b000, lat);
    check_eq("pop_lat", lat, 3);
    check_eq("pop_data", pop_data, 16'hBEEF);
    check_eq("pop_sp", sp, 12'hFFF);

    // POP on an empty stack
`ifdef STACK_BOUND_CHECK_EN
    rb = rd_addr_log.size();
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd1;
    @(negedge clk);
    op_valid = 1'b0;
    check_eq("uf_err", {err, mif.mem_req, done}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    check_eq("uf_err_pulse", {err, mif.mem_req, done}, 0);
    check_eq("uf_sp", sp, 12'hFFF);
    check_eq("uf_no_read", rd_addr_log.size(), rb);
`else
    rb = rd_addr_log.size();
    run_op(3'd1, 16'h0, 32'h0, 3'b000, lat);
    check_eq("uf_lat", lat, 3);
    check_eq("uf_addr", rd_addr_log[rb], 12'h000);
    check_eq("uf_sp", sp, 12'h000);
    check_eq("uf_err", err, 0);
`endif

    // Reset asserted mid-CALL acts immediately
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd2; op_pc = 32'h1111_2222;
    @(negedge clk);
    op_valid = 1'b0;
    check_eq("mid_call_req", mif.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_bus", {mif.mem_req, op_ready, done}, {1'b0, 1'b1, 1'b0});
    check_eq("arst_sp", sp, 12'hFFF);
    @(negedge clk); rst_n = 1'b1;

    // Flush during the second beat of RET
    run_op(3'd2, 16'h0, 32'hCAFE_0001, 3'b000, lat);
    check_eq("call2_sp", sp, 12'hFFD);
    rb = rd_addr_log.size();
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd3;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("fl_beat2", {mif.mem_req, mif.mem_we, mif.mem_addr}, {1'b1, 1'b0, 12'hFFF});
    flush = 1'b1;
    saw_done = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    check_eq("fl_no_done", saw_done, 0);
    check_eq("fl_idle", {op_ready, mif.mem_req}, {1'b1, 1'b0});
    check_eq("fl_sp", sp, 12'hFFD);
    check_eq("fl_reads", rd_addr_log.size() - rb, 2);
    check_eq("fl_pc_hold", pc_out, 32'h0);

    // flush with op_valid in IDLE drops the op
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd0; op_data = 16'h5A5A; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    check_eq("idle_flush_req", {mif.mem_req, op_ready}, {1'b0, 1'b1});
    @(negedge clk);
    check_eq("idle_flush_sp", {sp, done}, {12'hFFD, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
